// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with majority vote, configurable framing and error flags
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic                 rx_enb,
   input  logic                 rdy_clr,
   output logic                 rdy,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] LO   = SW'(OVERSAMPLE / 2 - 2);
   localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] HI   = SW'(OVERSAMPLE / 2);
   localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] TOP  = IW'(DATA_BITS - 1);
   localparam logic ODD = (PARITY == 2);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_HIGH} state_t;
   state_t               state;
   logic                 rx_m, rx_s;
   logic [SW-1:0]        sample;
   logic [IW-1:0]        index;
   logic [1:0]           hist;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shift;
   logic                 perr, ferr;
   logic                 vote, last_stop, done;
   assign vote      = (hist[0] & hist[1]) | (rx_s & (hist[0] | hist[1]));
   assign last_stop = (STOP_BITS == 1) || stop_idx;
   // word completes mid last stop bit so a following start edge is never missed
   assign done      = rx_enb && state == STOP && sample == HI && last_stop;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rx_m       <= 1'b1;
         rx_s       <= 1'b1;
         state      <= IDLE;
         sample     <= '0;
         index      <= '0;
         hist       <= '0;
         stop_idx   <= 1'b0;
         shift      <= '0;
         perr       <= 1'b0;
         ferr       <= 1'b0;
         rdy        <= 1'b0;
         data_out   <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         if (done) begin
            data_out   <= shift;
            parity_err <= perr;
            frame_err  <= ferr | ~vote;
            rdy        <= 1'b1;
            overrun    <= overrun | (rdy & ~rdy_clr);
         end else if (rdy_clr) begin
            rdy        <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
         end
         if (rx_enb) begin
            if (sample == LO) hist[0] <= rx_s;
            if (sample == MID) hist[1] <= rx_s;
            sample <= (state == IDLE || state == WAIT_HIGH || sample == LAST) ? '0 : sample + SW'(1);
            case (state)
               IDLE: begin
                  state    <= rx_s ? IDLE : START;
                  index    <= '0;
                  stop_idx <= 1'b0;
                  perr     <= 1'b0;
                  ferr     <= 1'b0;
               end
               START:
                  if (sample == HI && vote) state <= IDLE;
                  else if (sample == LAST) state <= DATA;
               DATA: begin
                  if (sample == HI) shift[index] <= vote;
                  if (sample == LAST) begin
                     index <= index + IW'(1);
                     if (index == TOP) state <= (PARITY != 0) ? PAR : STOP;
                  end
               end
               PAR: begin
                  if (sample == HI) perr <= vote ^ (^shift) ^ ODD;
                  if (sample == LAST) state <= STOP;
               end
               STOP: begin
                  if (sample == HI) begin
                     if (!vote) ferr <= 1'b1;
                     if (last_stop) state <= (ferr | ~vote) ? WAIT_HIGH : IDLE;
                  end
                  if (sample == LAST) stop_idx <= 1'b1;
               end
               WAIT_HIGH: state <= rx_s ? IDLE : WAIT_HIGH;
               default: state <= IDLE;
            endcase
         end
      end
endmodule
